// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 serial output stage: state encoding,
// colour ordering on the wire and the colour packing helper.
package ws2812_pkg;

  typedef enum logic {StGap, StSend} ws2812_state_e;

  localparam int unsigned bits_per_led = 24;

  // Level index per byte slot, first-sent slot in the top bits: G (1), R (0), B (2).
  localparam logic [5:0] colour_order = {2'd1, 2'd0, 2'd2};

  function automatic logic [23:0] pack_colour(input logic [7:0] level0,
                                               input logic [7:0] level1,
                                               input logic [7:0] level2);
    logic [23:0] colour;
    logic [1:0]  sel;
    colour = '0;
    for (int i = 0; i < 3; i++) begin
      sel = colour_order[5 - 2*i -: 2];
      case (sel)
        2'd0:    colour[23 - 8*i -: 8] = level0;
        2'd1:    colour[23 - 8*i -: 8] = level1;
        default: colour[23 - 8*i -: 8] = level2;
      endcase
    end
    return colour;
  endfunction

endpackage

// File: rtl/ws2812_bit.sv
// Single-bit NRZ pulse generator: times one bit of bit_len cycles and drives the
// line high for t0h or t1h cycles depending on the bit value.
module ws2812_bit #(
  parameter int unsigned bit_len = 20,
  parameter int unsigned t0h     = 6,
  parameter int unsigned t1h     = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_value,
  output logic line,
  output logic last_cycle,
  output logic active
);

  localparam int unsigned CntW = (bit_len > 1) ? $clog2(bit_len) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(bit_len - 1);
  localparam logic [CntW-1:0] HighT0  = CntW'(t0h);
  localparam logic [CntW-1:0] HighT1  = CntW'(t1h);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc, high_time;
  logic            line_q, line_d, active_q, active_d;

  assign high_time  = bit_value ? HighT1 : HighT0;
  assign cnt_inc    = cnt_q + CntW'(1);
  assign last_cycle = active_q && (cnt_q == LastCnt);

  always_comb begin
    cnt_d    = cnt_q;
    line_d   = line_q;
    active_d = active_q;
    if (start) begin
      // Cycle 0 of every bit is high because t0h is never zero.
      cnt_d    = '0;
      line_d   = 1'b1;
      active_d = 1'b1;
    end else if (last_cycle) begin
      cnt_d    = '0;
      line_d   = 1'b0;
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d  = cnt_inc;
      line_d = (cnt_inc < high_time);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      line_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      active_q <= active_d;
    end
  end

  assign line   = line_q;
  assign active = active_q;

endmodule

// File: rtl/ws2812_driver.sv
// WS2812 chain driver: snapshots one colour per frame and sends it to every LED,
// separated by a latch gap of reset_len low cycles.
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned num_leds  = 8,
  parameter int unsigned bit_len   = 20,
  parameter int unsigned t0h       = 6,
  parameter int unsigned t1h       = 13,
  parameter int unsigned reset_len = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] level0,
  input  logic [7:0] level1,
  input  logic [7:0] level2,
  output logic       data_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned GapW = $clog2(reset_len);
  localparam int unsigned LedW = (num_leds > 1) ? $clog2(num_leds) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(reset_len - 1);
  localparam logic [LedW-1:0] LedLast = LedW'(num_leds - 1);
  localparam logic [4:0]      BitLast = 5'(bits_per_led - 1);

  ws2812_state_e   state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [23:0]     colour_q, colour_d, shift_q, shift_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [LedW-1:0] led_cnt_q, led_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            bit_start, bit_last, bit_active;

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    colour_d     = colour_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    led_cnt_d    = led_cnt_q;
    frame_done_d = 1'b0;
    bit_start    = 1'b0;
    unique case (state_q)
      StGap: begin
        if (gap_q != GapLast) begin
          gap_d = gap_q + GapW'(1);
        end else if (enable) begin
          colour_d  = pack_colour(level0, level1, level2);
          shift_d   = pack_colour(level0, level1, level2);
          bit_cnt_d = '0;
          led_cnt_d = '0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (!bit_active) begin
          // Latch cycle: the first bit begins on the next edge.
          bit_start = 1'b1;
        end else if (bit_last) begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            if (led_cnt_q == LedLast) begin
              state_d      = StGap;
              gap_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              led_cnt_d = led_cnt_q + LedW'(1);
              shift_d   = colour_q;
              bit_start = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shift_d   = {shift_q[22:0], 1'b0};
            bit_start = 1'b1;
          end
        end
      end
      default: state_d = StGap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StGap;
      gap_q        <= '0;
      colour_q     <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      led_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      colour_q     <= colour_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      led_cnt_q    <= led_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  ws2812_bit #(
    .bit_len(bit_len),
    .t0h    (t0h),
    .t1h    (t1h)
  ) u_bit (
    .clk       (clk),
    .reset     (reset),
    .start     (bit_start),
    .bit_value (shift_q[23]),
    .line      (data_out),
    .last_cycle(bit_last),
    .active    (bit_active)
  );

  assign busy       = bit_active;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Self-checking bench for ws2812_driver: an edge-numbered timeline model predicts
// data_out/busy/frame_done every cycle, plus directed timing measurements.
module tb_ws2812_driver;

  localparam int NumLeds  = 2;
  localparam int BitLen   = 20;
  localparam int T0h      = 6;
  localparam int T1h      = 13;
  localparam int ResetLen = 100;
  localparam int FrameLen = NumLeds * 24 * BitLen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] level0 = 8'hFF;
  logic [7:0] level1 = 8'h00;
  logic [7:0] level2 = 8'h81;
  logic       data_out, busy, frame_done;

  int checks = 0;
  int errors = 0;

  ws2812_driver #(
    .num_leds (NumLeds),
    .bit_len  (BitLen),
    .t0h      (T0h),
    .t1h      (T1h),
    .reset_len(ResetLen)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .level0    (level0),
    .level1    (level1),
    .level2    (level2),
    .data_out  (data_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: edges are numbered; a frame may latch on any edge at or after
  // 'earliest' with enable high, then occupies the next FrameLen edges.
  int          edge_n = 0;
  int          earliest = 0;
  int          fstart = 0;
  bit          in_frame = 1'b0;
  bit          armed = 1'b0;
  logic [23:0] mcol = '0;

  always @(posedge clk) begin
    logic       r, en;
    logic [7:0] l0, l1, l2;
    logic [2:0] exp;
    int         k, bit_idx, c, high;
    r = reset; en = enable; l0 = level0; l1 = level1; l2 = level2;
    edge_n++;
    exp = 3'b000;
    if (r) begin
      armed    = 1'b1;
      in_frame = 1'b0;
      earliest = edge_n + ResetLen;
    end else begin
      if (in_frame && edge_n == fstart + FrameLen + 1) begin
        in_frame = 1'b0;
        earliest = edge_n + ResetLen;
        exp[0]   = 1'b1;
      end
      if (!in_frame && en && edge_n >= earliest) begin
        in_frame = 1'b1;
        fstart   = edge_n;
        mcol     = {l1, l0, l2};
      end
      if (in_frame && edge_n > fstart) begin
        k       = edge_n - fstart - 1;
        bit_idx = k / BitLen;
        c       = k % BitLen;
        high    = mcol[23 - (bit_idx % 24)] ? T1h : T0h;
        exp[2]  = (c < high);
        exp[1]  = 1'b1;
      end
    end
    #1;
    if (armed) check_eq("outputs", {29'b0, data_out, busy, frame_done}, {29'b0, exp});
  end

  task automatic cycles_to_rise(output int n, output int fd);
    n = 0;
    fd = 0;
    while (n < 5000) begin
      @(posedge clk); #1;
      n++;
      fd += int'(frame_done);
      if (data_out) break;
    end
  endtask

  task automatic measure_frame(output int cyc, output int highs, output int busys);
    cyc = 0; highs = 0; busys = 0;
    while (cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      highs += int'(data_out);
      busys += int'(busy);
      if (frame_done) break;
    end
  endtask

  initial begin
    int n, fd, cyc, highs, busys;

    // Reset, first frame and back-to-back frames with a mid-frame level change.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cycles_to_rise(n, fd);
    check_eq("first_rise", n, 101);
    repeat (300) @(posedge clk);
    @(negedge clk);
    level1 = 8'hAA;
    measure_frame(cyc, highs, busys);
    check_eq("frame1_busy_tail", busys, FrameLen - 301);
    measure_frame(cyc, highs, busys);
    check_eq("frame_period", cyc, 1061);
    check_eq("frame_busy", busys, 960);
    check_eq("frame2_highs", highs, 484);

    // Enable held low after reset.
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    level0 = 8'($urandom); level1 = 8'($urandom); level2 = 8'($urandom);
    @(negedge clk);
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      highs += int'(data_out) + int'(busy);
    end
    check_eq("enable_low_quiet", highs, 0);
    @(negedge clk);
    enable = 1'b1;
    cycles_to_rise(n, fd);
    check_eq("enable_to_rise", n, 2);

    // Reset in the middle of bit 30.
    repeat (30 * BitLen + 9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_data", {31'b0, data_out}, 0);
    check_eq("abort_busy", {31'b0, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    level0 = 8'h00; level1 = 8'h00; level2 = 8'h00;
    cycles_to_rise(n, fd);
    check_eq("abort_restart", n, 101);
    check_eq("abort_no_done", fd, 0);

    // All-zero frame then all-ones frame.
    measure_frame(cyc, highs, busys);
    check_eq("zeros_highs", highs + 1, 48 * T0h);
    @(negedge clk);
    level0 = 8'hFF; level1 = 8'hFF; level2 = 8'hFF;
    measure_frame(cyc, highs, busys);
    check_eq("ones_highs", highs, 48 * T1h);
    check_eq("ones_period", cyc, 1061);
    check_eq("ones_busy", busys, 960);

    // Random levels, enable toggling and occasional resets.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(200, 20)) @(negedge clk);
      level0 = 8'($urandom); level1 = 8'($urandom); level2 = 8'($urandom);
      enable = ($urandom_range(3, 0) != 0);
      if ($urandom_range(9, 0) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    enable = 1'b1;
    repeat (1200) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
